multi_edge_det: RTL and testbench
=================================

Name: multi_edge_det

Overview:
- Parametrised, multi-channel successor to the single-line edge detector.
- Per channel:
  - synchronises an asynchronous line;
  - glitch-filters it;
  - detects edges qualified by a per-channel mode (rise/fall/both/off);
  - emits one-cycle pulses plus sticky pending flags.
- Sits between raw serial/bus pins (UART RX, USB D+/D-, GPIO wake lines) and the protocol FSMs that consume start-of-frame or transition events.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- FILT_CYCLES, 0, extra consecutive cycles a new level must persist before acceptance (0..255); 0 = no filtering.
- IDLE_LEVEL, all ones (NUM_CH bits), per-channel reset/idle line level.
- CNT_W, 8, event counter width (used only with the optional feature).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- serial_in, in, NUM_CH, asynchronous input lines.
- mode, in, 2*NUM_CH, per-channel mode, channel i at bits [2i+1:2i]:
  - 00 off
  - 01 rising
  - 10 falling
  - 11 both
- clear, in, NUM_CH, per-channel clear of pending (and counter when enabled).
- level_out, out, NUM_CH, filtered, synchronised line level.
- edge_pulse, out, NUM_CH, one-cycle pulse per qualified edge.
- edge_rising, out, NUM_CH, valid with edge_pulse: 1 = rising, 0 = falling.
- pending, out, NUM_CH, sticky "qualified edge seen" flag.
- event_cnt, out, NUM_CH*CNT_W, per-channel event count; present only with EDGE_DET_COUNT_EN.

Behaviour:
- Reset, while rst high at a clk edge:
  - sync chain and level_out[i] <= IDLE_LEVEL[i];
  - filter counter <= 0;
  - edge_pulse, edge_rising, pending <= 0;
  - event_cnt <= 0.
  - rst mid-transition discards any partially filtered change. No edge is reported for a line already at non-idle level when rst releases until it actually toggles twice.
- Synchroniser: serial_in[i] is shifted through SYNC_STAGES flops; s[i] = last stage.
- Filter, per channel, when s[i] != level_out[i]:
  - if cnt == FILT_CYCLES: level_out <= s, cnt <= 0, raw edge occurs;
  - else cnt <= cnt + 1.
  - When s[i] == level_out[i], cnt <= 0.
  - A pulse at the synchroniser output shorter than FILT_CYCLES+1 cycles is suppressed entirely.
- Latency: input change to level_out/edge_pulse high = SYNC_STAGES+FILT_CYCLES+1 rising clk edges. With defaults, 3.
- Qualification: a raw edge is qualified if mode is 01 and the new level is 1, mode is 10 and the new level is 0, or mode is 11.
  - Mode 00: the filter still tracks level_out; no pulses, pending or counts.
- edge_pulse / edge_rising:
  - registered; update on the same edge as level_out;
  - edge_pulse is high exactly one cycle per qualified edge;
  - edge_rising = new level_out when edge_pulse = 1, else 0.
  - Back-to-back edges on consecutive cycles are possible only with FILT_CYCLES = 0, and yield consecutive pulses.
- pending[i]:
  - set by a qualified edge, cleared by clear[i];
  - simultaneous set and clear: set wins, so no event is lost.
- mode changes take effect for edges registered on the following clk edge; in-flight filter state is unaffected.
- Channels are fully independent; simultaneous edges on all channels all pulse in the same cycle.

Optional Feature:
- Macro EDGE_DET_COUNT_EN.
- Defined:
  - per-channel CNT_W-bit event_cnt increments on each qualified edge;
  - saturates at all ones (no wrap);
  - clear[i] zeroes it;
  - clear and increment in the same cycle gives event_cnt = 1.
- Undefined: the event_cnt port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package edge_det_pkg:
  - edge_mode_t enum (EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11);
  - constants MAX_SYNC_STAGES=4 and MAX_FILT_CYCLES=255.
- One sub-module, edge_det_chan:
  - single-channel sync + filter + qualify + pending (+ counter);
  - instantiated NUM_CH times in a generate loop;
  - the top only slices buses.

Test Plan:
- Reset, defaults, IDLE_LEVEL=4'hF, lines held high, rst 2 cycles: all outputs 0, level_out=4'hF. Then ch0 high->low, mode=10: edge_pulse[0]=1 exactly on edge 3, edge_rising[0]=0, pending[0]=1.
- Filter, FILT_CYCLES=3, ch1 mode=11, low pulse 3 cycles wide: no pulse, level_out[1] stays 1. Pulse 4 cycles wide: edge_pulse[1] at edge 6 (falling), then again for the rising return.
- Mode qualification, ch2 mode=01, toggle 1->0->1 with 10-cycle gaps: exactly one pulse, edge_rising[2]=1. Mode=00, same toggles: zero pulses, level_out[2] still follows.
- Sticky clear, ch3 pending=1: assert clear[3] in the same cycle as a new qualified edge -> pending[3] stays 1. Assert clear alone -> pending[3]=0 the next cycle.
- Reset mid-filter, FILT_CYCLES=3: assert rst 2 cycles into a valid transition -> no pulse, level_out returns to IDLE_LEVEL, counter restarts from 0 after release.
- With EDGE_DET_COUNT_EN, CNT_W=2, ch0 mode=11: 5 edges -> event_cnt ch0 = 3 (saturated). clear with a simultaneous edge -> 1.

Source files
------------

// File: rtl/edge_det_pkg.sv
// ---------------------------------------------------------------------------
// edge_det_pkg
//
// Purpose : Shared definitions for the multi-channel edge detector.
//           Holds the per-channel mode encoding, the supported range limits
//           for the synchroniser depth and glitch filter length, and the
//           helper that decides whether an accepted level change is an
//           event the channel should report.
//
// Contents:
//   edge_mode_t      - per-channel mode: off / rising / falling / both
//   MAX_SYNC_STAGES  - deepest synchroniser chain supported
//   MAX_FILT_CYCLES  - longest glitch filter supported
//   edge_qualifies() - mode + new level -> report this edge or not
// ---------------------------------------------------------------------------
package edge_det_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   localparam int MAX_SYNC_STAGES = 4;
   localparam int MAX_FILT_CYCLES = 255;

   // An accepted level change is reported when its direction matches the
   // channel mode. The new level alone gives the direction: 1 means the line
   // rose, 0 means it fell.
   function automatic logic edge_qualifies(input edge_mode_t m, input logic new_level);
      case (m)
         EDGE_RISE: return new_level;
         EDGE_FALL: return ~new_level;
         EDGE_BOTH: return 1'b1;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/edge_det_chan.sv
// ---------------------------------------------------------------------------
// edge_det_chan
//
// Purpose : One channel of the multi-channel edge detector. Synchronises an
//           asynchronous line, glitch-filters it, reports mode-qualified
//           edges as one-cycle pulses and keeps a sticky pending flag.
//           With EDGE_DET_COUNT_EN defined it also keeps a saturating count
//           of qualified edges.
//
// Optional feature macro: EDGE_DET_COUNT_EN (adds CNT_W and event_cnt)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   serial_in   in   asynchronous input line
//   mode        in   2-bit mode (edge_mode_t encoding)
//   clear       in   clears pending (and event_cnt when present)
//   level_out   out  filtered, synchronised line level
//   edge_pulse  out  one-cycle pulse per qualified edge
//   edge_rising out  direction of the pulsed edge (1 = rising), else 0
//   pending     out  sticky "qualified edge seen" flag
//   event_cnt   out  saturating qualified-edge count (EDGE_DET_COUNT_EN only)
// ---------------------------------------------------------------------------
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CYCLES = 0,
   parameter logic IDLE_LEVEL  = 1'b1
`ifdef EDGE_DET_COUNT_EN
   , parameter int CNT_W       = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic [1:0]       mode,
   input  logic             clear,
   output logic             level_out,
   output logic             edge_pulse,
   output logic             edge_rising,
   output logic             pending
`ifdef EDGE_DET_COUNT_EN
   , output logic [CNT_W-1:0] event_cnt
`endif
);

   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                           (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;
   localparam int FILT_N = (FILT_CYCLES < 0) ? 0 :
                           (FILT_CYCLES > MAX_FILT_CYCLES) ? MAX_FILT_CYCLES : FILT_CYCLES;
   localparam int FILT_W = $clog2(MAX_FILT_CYCLES + 1);
   localparam logic [FILT_W-1:0] FILT_LIMIT = FILT_W'(FILT_N);

   logic [SYNC_N-1:0] sync_q;
   logic [SYNC_N-1:0] sync_vld;
   logic [FILT_W-1:0] filt_cnt;
   logic              armed;
   logic              sync_level;
   logic              sync_valid;
   logic              differs;
   logic              accept;
   logic              qualified;

   assign sync_level = sync_q[SYNC_N-1];
   assign sync_valid = sync_vld[SYNC_N-1];
   assign differs    = armed && (sync_level != level_out);
   assign accept     = differs && (filt_cnt == FILT_LIMIT);
   assign qualified  = accept && edge_qualifies(edge_mode_t'(mode), sync_level);

   // Synchroniser chain. Reset loads the idle level so no false edge comes
   // out of the chain. A parallel valid chain marks which stages hold
   // genuine post-reset samples rather than the reset fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= {SYNC_N{IDLE_LEVEL}};
         sync_vld <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_N-2:0], serial_in};
         sync_vld <= {sync_vld[SYNC_N-2:0], 1'b1};
      end
   end

   // Arming. A line that is already away from idle when reset releases must
   // not be reported as an edge. The channel ignores the line (holding
   // level_out at idle) until a genuine synchronised sample shows the idle
   // level; from then on every accepted change is a real transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
      end else if (sync_valid && (sync_level == IDLE_LEVEL)) begin
         armed <= 1'b1;
      end
   end

   // Glitch filter. A differing synchronised level must be seen on
   // FILT_CYCLES+1 consecutive edges before it is accepted; any return to the
   // current level restarts the count, so shorter pulses vanish completely.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_out <= IDLE_LEVEL;
         filt_cnt  <= '0;
      end else if (differs) begin
         if (accept) begin
            level_out <= sync_level;
            filt_cnt  <= '0;
         end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
         end
      end else begin
         filt_cnt <= '0;
      end
   end

   // Event outputs, registered alongside level_out. pending gives priority to
   // a new qualified edge over clear so an event arriving with the clear is
   // never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_pulse  <= 1'b0;
         edge_rising <= 1'b0;
         pending     <= 1'b0;
      end else begin
         edge_pulse  <= qualified;
         edge_rising <= qualified & sync_level;
         pending     <= qualified | (pending & ~clear);
      end
   end

`ifdef EDGE_DET_COUNT_EN
   // Saturating event counter. A clear that coincides with a qualified edge
   // leaves a count of one, consistent with pending staying set.
   always_ff @(posedge clk) begin
      if (rst) begin
         event_cnt <= '0;
      end else if (clear) begin
         event_cnt <= qualified ? CNT_W'(1) : '0;
      end else if (qualified && (event_cnt != {CNT_W{1'b1}})) begin
         event_cnt <= event_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: rtl/multi_edge_det.sv
// ---------------------------------------------------------------------------
// multi_edge_det
//
// Purpose : Parametrised multi-channel edge detector sitting between raw
//           pins (UART RX, USB D+/D-, GPIO wake lines) and the protocol FSMs.
//           Each channel is an independent edge_det_chan; this level only
//           slices the buses.
//
// Optional feature macro: EDGE_DET_COUNT_EN (per-channel event counters)
//
// Parameters:
//   NUM_CH       number of channels (1..32)
//   SYNC_STAGES  synchroniser depth (2..4)
//   FILT_CYCLES  extra cycles a new level must persist (0..255)
//   IDLE_LEVEL   per-channel reset/idle level
//   CNT_W        event counter width (counting build only)
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   serial_in    [NUM_CH]       asynchronous input lines
//   mode         [2*NUM_CH]     channel i mode at [2i+1:2i]
//   clear        [NUM_CH]       per-channel pending/counter clear
//   level_out    [NUM_CH]       filtered line levels
//   edge_pulse   [NUM_CH]       one-cycle qualified edge pulses
//   edge_rising  [NUM_CH]       pulse direction (1 = rising)
//   pending      [NUM_CH]       sticky event flags
//   event_cnt    [NUM_CH*CNT_W] event counts (EDGE_DET_COUNT_EN only)
// ---------------------------------------------------------------------------
module multi_edge_det
   import edge_det_pkg::*;
#(
   parameter int                NUM_CH      = 4,
   parameter int                SYNC_STAGES = 2,
   parameter int                FILT_CYCLES = 0,
   parameter logic [NUM_CH-1:0] IDLE_LEVEL  = {NUM_CH{1'b1}},
   parameter int                CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     serial_in,
   input  logic [2*NUM_CH-1:0]   mode,
   input  logic [NUM_CH-1:0]     clear,
   output logic [NUM_CH-1:0]     level_out,
   output logic [NUM_CH-1:0]     edge_pulse,
   output logic [NUM_CH-1:0]     edge_rising,
   output logic [NUM_CH-1:0]     pending
`ifdef EDGE_DET_COUNT_EN
   , output logic [NUM_CH*CNT_W-1:0] event_cnt
`endif
);

`ifndef EDGE_DET_COUNT_EN
   // CNT_W sizes only the counters; the plain build keeps it so both builds
   // share one parameter list.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

   // One fully independent channel per line.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      edge_det_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CYCLES (FILT_CYCLES),
         .IDLE_LEVEL  (IDLE_LEVEL[i])
`ifdef EDGE_DET_COUNT_EN
         , .CNT_W     (CNT_W)
`endif
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .serial_in   (serial_in[i]),
         .mode        (mode[2*i +: 2]),
         .clear       (clear[i]),
         .level_out   (level_out[i]),
         .edge_pulse  (edge_pulse[i]),
         .edge_rising (edge_rising[i]),
         .pending     (pending[i])
`ifdef EDGE_DET_COUNT_EN
         , .event_cnt (event_cnt[i*CNT_W +: CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_multi_edge_det.sv
// ---------------------------------------------------------------------------
// tb_multi_edge_det
//
// Purpose : Self-checking bench for multi_edge_det. Two instances share the
//           clock: dut0 with FILT_CYCLES=0 and dut1 with FILT_CYCLES=3, both
//           4 channels, SYNC_STAGES=2, IDLE_LEVEL=4'hF, CNT_W=2.
//           A behavioural model predicts every output each cycle, and the
//           directed sequence adds hand-computed literal expectations.
//           Counter checks are active when EDGE_DET_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_multi_edge_det;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic [3:0] sin0, sin1, clr0, clr1;
   logic [7:0] mode0, mode1;
   logic [3:0] lvl0, pul0, ris0, pen0;
   logic [3:0] lvl1, pul1, ris1, pen1;
`ifdef EDGE_DET_COUNT_EN
   logic [7:0] evt0, evt1;
`endif

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   multi_edge_det #(
      .NUM_CH(4), .SYNC_STAGES(SYNC), .FILT_CYCLES(0), .IDLE_LEVEL(4'hF), .CNT_W(2)
   ) dut0 (
      .clk(clk), .rst(rst0), .serial_in(sin0), .mode(mode0), .clear(clr0),
      .level_out(lvl0), .edge_pulse(pul0), .edge_rising(ris0), .pending(pen0)
`ifdef EDGE_DET_COUNT_EN
      , .event_cnt(evt0)
`endif
   );

   multi_edge_det #(
      .NUM_CH(4), .SYNC_STAGES(SYNC), .FILT_CYCLES(3), .IDLE_LEVEL(4'hF), .CNT_W(2)
   ) dut1 (
      .clk(clk), .rst(rst1), .serial_in(sin1), .mode(mode1), .clear(clr1),
      .level_out(lvl1), .edge_pulse(pul1), .edge_rising(ris1), .pending(pen1)
`ifdef EDGE_DET_COUNT_EN
      , .event_cnt(evt1)
`endif
   );

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model. The synchronised view of a line at edge k is simply
   // the raw sample taken SYNC edges earlier, provided no reset happened in
   // between; otherwise the line reads as idle and is not yet genuine.
   logic [3:0] hist [2][4096];
   int         last_rst [2] = '{0, 0};
   int         cyc = 0;
   bit         m_level [2][4];
   bit         m_armed [2][4];
   int         m_run   [2][4];
   bit         m_pulse [2][4];
   bit         m_rise  [2][4];
   bit         m_pend  [2][4];
   int         m_cnt   [2][4];

   task automatic model_step(input int d, input logic r, input logic [3:0] x,
                             input logic [7:0] md, input logic [3:0] cl, input int filt);
      bit s, genuine, accepted, q;
      int idx;
      logic [1:0] m;
      if (r) begin
         last_rst[d] = cyc;
         for (int c = 0; c < 4; c++) begin
            m_level[d][c] = 1'b1;
            m_armed[d][c] = 1'b0;
            m_run[d][c]   = 0;
            m_pulse[d][c] = 1'b0;
            m_rise[d][c]  = 1'b0;
            m_pend[d][c]  = 1'b0;
            m_cnt[d][c]   = 0;
         end
      end else begin
         idx = cyc - SYNC;
         for (int c = 0; c < 4; c++) begin
            genuine = (idx > last_rst[d]);
            s = genuine ? hist[d][idx][c] : 1'b1;
            accepted = 1'b0;
            if (!m_armed[d][c]) begin
               if (genuine && s) m_armed[d][c] = 1'b1;
            end else if (s != m_level[d][c]) begin
               if (m_run[d][c] == filt) begin
                  m_level[d][c] = s;
                  m_run[d][c]   = 0;
                  accepted      = 1'b1;
               end else begin
                  m_run[d][c]++;
               end
            end else begin
               m_run[d][c] = 0;
            end
            m = md[2*c +: 2];
            q = accepted && ((m == 2'd3) || (m == 2'd1 && s) || (m == 2'd2 && !s));
            m_pulse[d][c] = q;
            m_rise[d][c]  = q && s;
            if (q) m_pend[d][c] = 1'b1;
            else if (cl[c]) m_pend[d][c] = 1'b0;
            if (cl[c]) m_cnt[d][c] = q ? 1 : 0;
            else if (q && m_cnt[d][c] < 3) m_cnt[d][c]++;
         end
      end
      hist[d][cyc] = x;
   endtask

   // Compare process: advance the model on each rising edge with the inputs
   // the DUTs sampled, then check every output shortly after the edge.
   always @(posedge clk) begin : compare_proc
      logic [3:0] e_lvl, e_pul, e_ris, e_pen;
      logic [7:0] e_cnt;
      model_step(0, rst0, sin0, mode0, clr0, 0);
      model_step(1, rst1, sin1, mode1, clr1, 3);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) begin
            e_lvl[c] = m_level[d][c];
            e_pul[c] = m_pulse[d][c];
            e_ris[c] = m_rise[d][c];
            e_pen[c] = m_pend[d][c];
            e_cnt[2*c +: 2] = 2'(m_cnt[d][c]);
         end
         if (d == 0) begin
            check_output("d0 level_out", 32'(lvl0), 32'(e_lvl));
            check_output("d0 edge_pulse", 32'(pul0), 32'(e_pul));
            check_output("d0 edge_rising", 32'(ris0), 32'(e_ris));
            check_output("d0 pending", 32'(pen0), 32'(e_pen));
`ifdef EDGE_DET_COUNT_EN
            check_output("d0 event_cnt", 32'(evt0), 32'(e_cnt));
`endif
         end else begin
            check_output("d1 level_out", 32'(lvl1), 32'(e_lvl));
            check_output("d1 edge_pulse", 32'(pul1), 32'(e_pul));
            check_output("d1 edge_rising", 32'(ris1), 32'(e_ris));
            check_output("d1 pending", 32'(pen1), 32'(e_pen));
`ifdef EDGE_DET_COUNT_EN
            check_output("d1 event_cnt", 32'(evt1), 32'(e_cnt));
`endif
         end
      end
   end

   // Directed sequence with literal expectations. Inputs change on the
   // falling edge; literal checks read outputs on the falling edge too.
   initial begin : apply_stimulus
      int np, nr;
      logic [3:0] exp_r;
      rst0 = 1'b1; rst1 = 1'b1;
      sin0 = 4'hF; sin1 = 4'hF;
      clr0 = 4'h0; clr1 = 4'h0;
      mode0 = 8'h00; mode1 = 8'h00;
      wait_cycles(2);

      // Reset state
      check_output("reset level d0", 32'(lvl0), 32'hF);
      check_output("reset pulse d0", 32'(pul0), 32'h0);
      check_output("reset pend d0", 32'(pen0), 32'h0);
      check_output("reset level d1", 32'(lvl1), 32'hF);
      rst0 = 1'b0; rst1 = 1'b0;
      wait_cycles(4);

      // Falling edge on ch0, mode falling: pulse exactly on the 3rd edge
      mode0[1:0] = 2'b10;
      sin0[0] = 1'b0;
      wait_cycles(2);
      check_output("t1 no early pulse", 32'(pul0[0]), 32'd0);
      wait_cycles(1);
      check_output("t1 pulse edge3", 32'(pul0[0]), 32'd1);
      check_output("t1 falling dir", 32'(ris0[0]), 32'd0);
      check_output("t1 pending", 32'(pen0[0]), 32'd1);
      check_output("t1 level", 32'(lvl0[0]), 32'd0);
      wait_cycles(1);
      check_output("t1 pulse one cycle", 32'(pul0[0]), 32'd0);

      // Filter: 3-cycle low glitch on dut1 ch1 is suppressed
      mode1[3:2] = 2'b11;
      sin1[1] = 1'b0;
      wait_cycles(3);
      sin1[1] = 1'b1;
      np = 0;
      for (int k = 0; k < 12; k++) begin
         wait_cycles(1);
         if (pul1[1]) np++;
      end
      check_output("t2 glitch pulses", 32'(np), 32'd0);
      check_output("t2 glitch level", 32'(lvl1[1]), 32'd1);

      // 4-cycle low pulse: falling pulse on edge 6, rising pulse on edge 10
      sin1[1] = 1'b0;
      wait_cycles(4);
      sin1[1] = 1'b1;
      wait_cycles(1);
      check_output("t2 no pulse edge5", 32'(pul1[1]), 32'd0);
      wait_cycles(1);
      check_output("t2 fall pulse edge6", 32'(pul1[1]), 32'd1);
      check_output("t2 fall dir", 32'(ris1[1]), 32'd0);
      check_output("t2 fall level", 32'(lvl1[1]), 32'd0);
      wait_cycles(3);
      check_output("t2 no pulse edge9", 32'(pul1[1]), 32'd0);
      wait_cycles(1);
      check_output("t2 rise pulse edge10", 32'(pul1[1]), 32'd1);
      check_output("t2 rise dir", 32'(ris1[1]), 32'd1);

      // Mode rising on dut0 ch2: one pulse for 1->0->1
      mode0[5:4] = 2'b01;
      for (int pass = 0; pass < 2; pass++) begin
         np = 0; nr = 0;
         sin0[2] = 1'b0;
         for (int k = 0; k < 10; k++) begin
            wait_cycles(1);
            if (pul0[2]) begin np++; if (ris0[2]) nr++; end
         end
         check_output("t3 level follows low", 32'(lvl0[2]), 32'd0);
         sin0[2] = 1'b1;
         for (int k = 0; k < 10; k++) begin
            wait_cycles(1);
            if (pul0[2]) begin np++; if (ris0[2]) nr++; end
         end
         check_output("t3 level follows high", 32'(lvl0[2]), 32'd1);
         if (pass == 0) begin
            check_output("t3 rise-mode pulses", 32'(np), 32'd1);
            check_output("t3 rise-mode dir", 32'(nr), 32'd1);
            mode0[5:4] = 2'b00;
         end else begin
            check_output("t3 off-mode pulses", 32'(np), 32'd0);
         end
      end

      // Sticky clear on dut0 ch3
      mode0[7:6] = 2'b11;
      sin0[3] = 1'b0;
      wait_cycles(4);
      check_output("t4 pending set", 32'(pen0[3]), 32'd1);
      sin0[3] = 1'b1;
      wait_cycles(2);
      clr0[3] = 1'b1;
      wait_cycles(1);
      clr0[3] = 1'b0;
      check_output("t4 edge with clear", 32'(pul0[3]), 32'd1);
      check_output("t4 set wins", 32'(pen0[3]), 32'd1);
      wait_cycles(2);
      clr0[3] = 1'b1;
      wait_cycles(1);
      clr0[3] = 1'b0;
      check_output("t4 clear alone", 32'(pen0[3]), 32'd0);
      wait_cycles(1);
      check_output("t4 stays clear", 32'(pen0[3]), 32'd0);

      // Back-to-back edges with no filtering: 1-cycle low on dut0 ch1
      mode0[3:2] = 2'b11;
      sin0[1] = 1'b0;
      wait_cycles(1);
      sin0[1] = 1'b1;
      wait_cycles(2);
      check_output("t5 b2b fall pulse", 32'(pul0[1]), 32'd1);
      check_output("t5 b2b fall dir", 32'(ris0[1]), 32'd0);
      wait_cycles(1);
      check_output("t5 b2b rise pulse", 32'(pul0[1]), 32'd1);
      check_output("t5 b2b rise dir", 32'(ris0[1]), 32'd1);

      // Reset two cycles into a filtered transition on dut1 ch0
      mode1[1:0] = 2'b11;
      sin1[0] = 1'b0;
      wait_cycles(2);
      rst1 = 1'b1;
      wait_cycles(2);
      rst1 = 1'b0;
      np = 0;
      for (int k = 0; k < 12; k++) begin
         wait_cycles(1);
         if (pul1[0]) np++;
      end
      check_output("t6 no pulse after rst", 32'(np), 32'd0);
      check_output("t6 level idle", 32'(lvl1[0]), 32'd1);
      check_output("t6 pending clear", 32'(pen1[0]), 32'd0);
      sin1[0] = 1'b1;
      wait_cycles(6);
      sin1[0] = 1'b0;
      wait_cycles(5);
      check_output("t6 no pulse edge5", 32'(pul1[0]), 32'd0);
      wait_cycles(1);
      check_output("t6 full-latency pulse", 32'(pul1[0]), 32'd1);

      // Counter saturation on dut0 ch0, mode both
      mode0[1:0] = 2'b11;
      clr0[0] = 1'b1;
      wait_cycles(1);
      clr0[0] = 1'b0;
      np = 0;
      for (int e = 0; e < 5; e++) begin
         sin0[0] = ~sin0[0];
         for (int k = 0; k < 5; k++) begin
            wait_cycles(1);
            if (pul0[0]) np++;
         end
      end
      check_output("t7 five pulses", 32'(np), 32'd5);
`ifdef EDGE_DET_COUNT_EN
      check_output("t7 cnt saturated", 32'(evt0[1:0]), 32'd3);
`endif
      sin0[0] = ~sin0[0];
      wait_cycles(2);
      clr0[0] = 1'b1;
      wait_cycles(1);
      clr0[0] = 1'b0;
      check_output("t7 clear+edge pulse", 32'(pul0[0]), 32'd1);
`ifdef EDGE_DET_COUNT_EN
      check_output("t7 clear+edge cnt", 32'(evt0[1:0]), 32'd1);
`endif

      // All channels toggling together pulse in the same cycle
      mode0 = 8'hFF;
      wait_cycles(4);
      sin0 = ~sin0;
      exp_r = sin0;
      wait_cycles(3);
      check_output("t8 all pulse", 32'(pul0), 32'hF);
      check_output("t8 all dir", 32'(ris0), 32'(exp_r));

      wait_cycles(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
